// File: rtl/issue_ctrl_pkg.sv
// Shared opcode constants and controller state encoding for issue_ctrl.
// Latency: none (declarations only).
// Backpressure: n/a.
package issue_ctrl_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SERIAL = 2'd2
    } state_e;

endpackage

// File: rtl/issue_opdec.sv
// Maps a decoded opcode to the register operands it reads and writes.
// Latency: combinational.
// Backpressure: none; pure decode.
module issue_opdec
    import issue_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic       o_uses_rs1,
    output logic       o_uses_rs2,
    output logic       o_writes_rd
);

    always_comb begin
        o_uses_rs1  = 1'b0;
        o_uses_rs2  = 1'b0;
        o_writes_rd = 1'b0;
        case (i_opcode)
            OP_LUI, OP_AUIPC, OP_JAL: o_writes_rd = 1'b1;
            OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM: begin
                o_uses_rs1  = 1'b1;
                o_writes_rd = 1'b1;
            end
            OP_BRANCH, OP_STORE: begin
                o_uses_rs1 = 1'b1;
                o_uses_rs2 = 1'b1;
            end
            OP_OP: begin
                o_uses_rs1  = 1'b1;
                o_uses_rs2  = 1'b1;
                o_writes_rd = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/issue_ctrl.sv
// Scoreboard issue controller: RAW/WAW stall, SYSTEM serialization behind a drained pipe.
// Latency: zero-cycle issue; scoreboard/state update at the next edge.
// Backpressure: o_stall holds decode; ISSUE_WB_BYPASS_EN lets same-cycle writeback hide hazards.
module issue_ctrl
    import issue_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       rst_n,
    input  logic       i_dec_valid,
    input  logic [6:0] i_opcode,
    input  logic [4:0] i_rs1_addr,
    input  logic [4:0] i_rs2_addr,
    input  logic [4:0] i_rd_addr,
    input  logic       i_wb_valid,
    input  logic [4:0] i_wb_rd_addr,
    input  logic       i_redirect,
    input  logic       i_sys_done,
    output logic       o_issue,
    output logic       o_stall,
    output logic       o_flush,
    output logic       o_sb_empty,
    output logic       o_serial
);

    logic [31:0] sb_q, sb_d;
    state_e      state_q, state_d;
    logic        uses_rs1, uses_rs2, writes_rd;
    logic [31:0] wb_clr, rd_set, sb_eff;
    logic        is_sys, hazard, issue;

    issue_opdec u_opdec (
        .i_opcode    (i_opcode),
        .o_uses_rs1  (uses_rs1),
        .o_uses_rs2  (uses_rs2),
        .o_writes_rd (writes_rd)
    );

    assign wb_clr = (i_wb_valid && (i_wb_rd_addr != 5'd0)) ? (32'd1 << i_wb_rd_addr) : 32'd0;

`ifdef ISSUE_WB_BYPASS_EN
    // A register retiring this cycle is already readable through the regfile.
    assign sb_eff = sb_q & ~wb_clr;
`else
    assign sb_eff = sb_q;
`endif

    assign is_sys = (i_opcode == OP_SYSTEM);
    assign hazard = (uses_rs1  && (i_rs1_addr != 5'd0) && sb_eff[i_rs1_addr]) ||
                    (uses_rs2  && (i_rs2_addr != 5'd0) && sb_eff[i_rs2_addr]) ||
                    (writes_rd && (i_rd_addr  != 5'd0) && sb_eff[i_rd_addr]);

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (i_dec_valid && !i_redirect) begin
                    if (is_sys)       state_d = ST_DRAIN;
                    else if (!hazard) issue   = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (i_redirect) begin
                    state_d = ST_RUN;
                end else if (i_dec_valid && is_sys && (sb_eff == 32'd0)) begin
                    issue   = 1'b1;
                    state_d = ST_SERIAL;
                end
            end
            ST_SERIAL: begin
                if (i_sys_done) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Set after clear so an issue and a writeback to the same register leave it pending.
    assign rd_set = (issue && writes_rd && (i_rd_addr != 5'd0)) ? (32'd1 << i_rd_addr) : 32'd0;
    assign sb_d   = (sb_q & ~wb_clr) | rd_set;

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q    <= 32'd0;
            state_q <= ST_RUN;
        end else begin
            sb_q    <= sb_d;
            state_q <= state_d;
        end
    end

    assign o_issue    = issue & rst_n;
    assign o_stall    = i_dec_valid & ~issue & ~i_redirect & rst_n;
    assign o_flush    = i_redirect & rst_n;
    assign o_sb_empty = (sb_q == 32'd0);
    assign o_serial   = (state_q != ST_RUN);

endmodule

// File: tb/tb_issue_ctrl.sv
module tb_issue_ctrl;
    import issue_ctrl_pkg::*;

`ifdef ISSUE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       rst_n;
    logic       i_dec_valid;
    logic [6:0] i_opcode;
    logic [4:0] i_rs1_addr, i_rs2_addr, i_rd_addr, i_wb_rd_addr;
    logic       i_wb_valid, i_redirect, i_sys_done;
    logic       o_issue, o_stall, o_flush, o_sb_empty, o_serial;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending flags per register and a mode 0=RUN 1=DRAIN 2=SERIAL
    bit pend [32];
    int mode;
    int nxt_mode;
    bit exp_issue;

    always #5 i_clk = ~i_clk;

    issue_ctrl dut (
        .i_clk        (i_clk),
        .rst_n        (rst_n),
        .i_dec_valid  (i_dec_valid),
        .i_opcode     (i_opcode),
        .i_rs1_addr   (i_rs1_addr),
        .i_rs2_addr   (i_rs2_addr),
        .i_rd_addr    (i_rd_addr),
        .i_wb_valid   (i_wb_valid),
        .i_wb_rd_addr (i_wb_rd_addr),
        .i_redirect   (i_redirect),
        .i_sys_done   (i_sys_done),
        .o_issue      (o_issue),
        .o_stall      (o_stall),
        .o_flush      (o_flush),
        .o_sb_empty   (o_sb_empty),
        .o_serial     (o_serial)
    );

    function automatic bit m_rs1(input logic [6:0] op);
        return op inside {7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011,
                          7'b0010011, 7'b0110011, 7'b1110011};
    endfunction
    function automatic bit m_rs2(input logic [6:0] op);
        return op inside {7'b1100011, 7'b0100011, 7'b0110011};
    endfunction
    function automatic bit m_rd(input logic [6:0] op);
        return op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                          7'b0000011, 7'b0010011, 7'b0110011, 7'b1110011};
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Is register r still blocking in this cycle, given the writeback inputs
    function automatic bit busy(input int r);
        if (r == 0) return 1'b0;
        if (BYP && i_wb_valid && (int'(i_wb_rd_addr) == r)) return 1'b0;
        return pend[r];
    endfunction

    task automatic model_reset();
        foreach (pend[i]) pend[i] = 1'b0;
        mode = 0;
    endtask

    task automatic step(input logic v, input logic [6:0] op, input int r1, input int r2, input int rd,
                        input logic wv, input int wrd, input logic redir, input logic sdone);
        bit haz, any_pend, any_busy;
        i_dec_valid  = v;
        i_opcode     = op;
        i_rs1_addr   = 5'(r1);
        i_rs2_addr   = 5'(r2);
        i_rd_addr    = 5'(rd);
        i_wb_valid   = wv;
        i_wb_rd_addr = 5'(wrd);
        i_redirect   = redir;
        i_sys_done   = sdone;
        #1;
        haz = (m_rs1(op) && busy(r1)) || (m_rs2(op) && busy(r2)) || (m_rd(op) && busy(rd));
        any_pend = 1'b0;
        any_busy = 1'b0;
        for (int r = 1; r < 32; r++) begin
            if (pend[r]) any_pend = 1'b1;
            if (busy(r)) any_busy = 1'b1;
        end
        exp_issue = 1'b0;
        nxt_mode  = mode;
        if (mode == 0) begin
            if (v && !redir && op == OP_SYSTEM) nxt_mode = 1;
            else exp_issue = v && !redir && !haz;
        end else if (mode == 1) begin
            if (redir) nxt_mode = 0;
            else if (v && op == OP_SYSTEM && !any_busy) begin
                exp_issue = 1'b1;
                nxt_mode  = 2;
            end
        end else begin
            if (sdone) nxt_mode = 0;
        end
        check("issue",    o_issue,    exp_issue);
        check("stall",    o_stall,    v && !exp_issue && !redir);
        check("flush",    o_flush,    redir);
        check("sb_empty", o_sb_empty, !any_pend);
        check("serial",   o_serial,   mode != 0);
    endtask

    task automatic clk();
        if (i_wb_valid && i_wb_rd_addr != 5'd0) pend[i_wb_rd_addr] = 1'b0;
        if (exp_issue && m_rd(i_opcode) && i_rd_addr != 5'd0) pend[i_rd_addr] = 1'b1;
        mode = nxt_mode;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_wb(input int r);
        step(1'b0, OP_IMM, 0, 0, 0, 1'b1, r, 1'b0, 1'b0);
        clk();
    endtask

    localparam logic [6:0] OPS [11] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                                        OP_STORE, OP_IMM, OP_OP, OP_SYSTEM, 7'b1111111};

    initial begin
        rst_n = 1'b0;
        i_dec_valid = 1'b1; i_opcode = OP_IMM; i_rs1_addr = '0; i_rs2_addr = '0; i_rd_addr = 5'd1;
        i_wb_valid = 1'b0; i_wb_rd_addr = '0; i_redirect = 1'b1; i_sys_done = 1'b0;
        model_reset();
        #2;
        check("rst_issue", o_issue, 1'b0);
        check("rst_stall", o_stall, 1'b0);
        check("rst_flush", o_flush, 1'b0);
        check("rst_empty", o_sb_empty, 1'b1);
        check("rst_serial", o_serial, 1'b0);
        #10 rst_n = 1'b1;
        @(posedge i_clk); #1;

        // RAW: addi x5 then add x6,x5,x1
        step(1, OP_IMM, 0, 0, 5, 0, 0, 0, 0);
        check("raw_first_issue", o_issue, 1'b1);
        clk();
        step(1, OP_OP, 5, 1, 6, 0, 0, 0, 0);
        check("raw_stall", o_stall, 1'b1);
        check("raw_noissue", o_issue, 1'b0);
        clk();
        step(1, OP_OP, 5, 1, 6, 1, 5, 0, 0);
        check("raw_wb_cycle", o_issue, BYP);
        clk();
        if (!BYP) begin
            step(1, OP_OP, 5, 1, 6, 0, 0, 0, 0);
            check("raw_after_wb", o_issue, 1'b1);
            clk();
        end
        idle_wb(6);

        // x0 destination never tracked
        for (int k = 0; k < 3; k++) begin
            step(1, OP_IMM, 0, 0, 0, 0, 0, 0, 0);
            check("x0_issue", o_issue, 1'b1);
            clk();
            check("x0_empty", o_sb_empty, 1'b1);
        end

        // WAW: lw x7 twice
        step(1, OP_LOAD, 1, 0, 7, 0, 0, 0, 0);
        clk();
        step(1, OP_LOAD, 2, 0, 7, 0, 0, 0, 0);
        check("waw_stall", o_stall, 1'b1);
        clk();
        step(1, OP_LOAD, 2, 0, 7, 1, 7, 0, 0);
        check("waw_wb_cycle", o_issue, BYP);
        clk();
        if (!BYP) begin
            step(1, OP_LOAD, 2, 0, 7, 0, 0, 0, 0);
            check("waw_issue", o_issue, 1'b1);
            clk();
        end
        idle_wb(7);

        // Set and clear of x9 in one cycle: set wins
        step(1, OP_IMM, 0, 0, 9, 1, 9, 0, 0);
        clk();
        check("collide_pending", o_sb_empty, 1'b0);
        step(1, OP_OP, 9, 0, 1, 0, 0, 0, 0);
        check("collide_stall", o_stall, 1'b1);
        clk();
        idle_wb(9);

        // SYSTEM serialization behind pending x3
        step(1, OP_IMM, 0, 0, 3, 0, 0, 0, 0);
        clk();
        step(1, OP_SYSTEM, 0, 0, 4, 0, 0, 0, 0);
        check("sys_enter_stall", o_stall, 1'b1);
        clk();
        check("sys_drain_serial", o_serial, 1'b1);
        step(1, OP_SYSTEM, 0, 0, 4, 1, 3, 0, 0);
        check("sys_drain_wb", o_issue, BYP);
        clk();
        if (!BYP) begin
            step(1, OP_SYSTEM, 0, 0, 4, 0, 0, 0, 0);
            check("sys_issue", o_issue, 1'b1);
            clk();
        end
        step(1, OP_IMM, 0, 0, 10, 0, 0, 0, 0);
        check("serial_stall", o_stall, 1'b1);
        clk();
        step(1, OP_IMM, 0, 0, 10, 0, 0, 0, 1);
        check("serial_done_noissue", o_issue, 1'b0);
        clk();
        check("back_to_run", o_serial, 1'b0);
        step(1, OP_IMM, 0, 0, 10, 0, 0, 0, 0);
        check("run_issue", o_issue, 1'b1);
        clk();
        idle_wb(4);
        idle_wb(10);

        // Redirect in a clean RUN cycle
        step(1, OP_IMM, 0, 0, 11, 0, 0, 1, 0);
        check("redir_issue", o_issue, 1'b0);
        check("redir_flush", o_flush, 1'b1);
        check("redir_stall", o_stall, 1'b0);
        clk();
        check("redir_noset", o_sb_empty, 1'b1);

        // Redirect out of DRAIN
        step(1, OP_IMM, 0, 0, 12, 0, 0, 0, 0);
        clk();
        step(1, OP_SYSTEM, 0, 0, 0, 0, 0, 0, 0);
        clk();
        step(0, OP_IMM, 0, 0, 0, 0, 0, 1, 0);
        clk();
        check("redir_drain_run", o_serial, 1'b0);
        idle_wb(12);

        // Async reset while draining with x8..x11 pending
        for (int r = 8; r < 12; r++) begin
            step(1, OP_IMM, 0, 0, r, 0, 0, 0, 0);
            clk();
        end
        step(1, OP_SYSTEM, 0, 0, 0, 0, 0, 0, 0);
        clk();
        step(1, OP_SYSTEM, 0, 0, 0, 0, 0, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_serial", o_serial, 1'b0);
        check("arst_empty", o_sb_empty, 1'b1);
        check("arst_issue", o_issue, 1'b0);
        check("arst_stall", o_stall, 1'b0);
        check("arst_flush", o_flush, 1'b0);
        model_reset();
        @(negedge i_clk);
        rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Random traffic over a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            automatic int wr = $urandom_range(0, 7);
            step(($urandom_range(0, 99) < 85), OPS[$urandom_range(0, 10)],
                 $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 ($urandom_range(0, 99) < 40), wr,
                 ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 15));
            clk();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
